// File: rtl/texture_arbiter.sv
// Round-robin arbiter sharing one synchronous texture ROM between two texel fetchers.
// Each accepted request returns its texel to the owning channel exactly three edges later.
module texture_arbiter #(
    parameter int TEX_BITS  = 4,
    parameter int IDX_BITS  = 5,
    parameter int DATA_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [TEX_BITS-1:0]  req0_texture,
    input  logic [IDX_BITS-1:0]  req0_y,
    input  logic [IDX_BITS-1:0]  req0_x,
    output logic                 rsp0_valid,
    output logic [DATA_BITS-1:0] rsp0_data,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [TEX_BITS-1:0]  req1_texture,
    input  logic [IDX_BITS-1:0]  req1_y,
    input  logic [IDX_BITS-1:0]  req1_x,
    output logic                 rsp1_valid,
    output logic [DATA_BITS-1:0] rsp1_data,

    output logic [TEX_BITS-1:0]  rom_texture,
    output logic [IDX_BITS-1:0]  rom_y_idx,
    output logic [IDX_BITS-1:0]  rom_x_idx,
    input  logic [DATA_BITS-1:0] rom_val
);

    logic                 last_grant;   // 1 = channel 1 was granted most recently
    logic                 grant0;
    logic                 grant1;
    logic                 s1_busy;
    logic                 s1_id;
    logic                 s2_busy;
    logic                 s2_id;
    logic [DATA_BITS-1:0] rsp_data;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && en) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= 1'b1;
            rom_texture <= '0;
            rom_y_idx   <= '0;
            rom_x_idx   <= '0;
            s1_busy     <= 1'b0;
            s1_id       <= 1'b0;
            s2_busy     <= 1'b0;
            s2_id       <= 1'b0;
            rsp_data    <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
        end else begin
            if (grant0) begin
                rom_texture <= req0_texture;
                rom_y_idx   <= req0_y;
                rom_x_idx   <= req0_x;
                last_grant  <= 1'b0;
            end else if (grant1) begin
                rom_texture <= req1_texture;
                rom_y_idx   <= req1_y;
                rom_x_idx   <= req1_x;
                last_grant  <= 1'b1;
            end
            // Tag stage 2 lines up with the ROM data registered from the stage-1 address.
            s1_busy <= grant0 | grant1;
            s1_id   <= grant1;
            s2_busy <= s1_busy;
            s2_id   <= s1_id;
            if (s2_busy) begin
                rsp_data <= rom_val;
            end
            rsp0_valid <= s2_busy & ~s2_id;
            rsp1_valid <= s2_busy & s2_id;
        end
    end

    assign rsp0_data = rsp_data;
    assign rsp1_data = rsp_data;

endmodule

// File: doc/texture_arbiter.md
# texture_arbiter

Shares the single synchronous-read texture ROM (16 textures × 32×32 texels × 4bpp, one registered read per clock) between two texel fetchers: channel 0 (mode7 floor renderer) and channel 1 (sprite/overlay renderer). Accepts one request per cycle via valid/ready handshakes and arbitrates round-robin on contention. It drives the ROM address, tracks which channel owns each in-flight read, and returns each texel to its owner at a fixed latency. Sits between the renderers and the texture ROM instance in the video pipeline.

## Interface
- TEX_BITS, default 4: texture select width.
- IDX_BITS, default 5: x/y texel index width.
- DATA_BITS, default 4: texel width.

- clk  in  1  pixel/system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  arbitration enable; low = no grants issued.
- req0_valid  in  1  channel 0 request present.
- req0_ready  out  1  channel 0 granted this cycle.
- req0_texture  in  TEX_BITS  channel 0 texture select.
- req0_y  in  IDX_BITS  channel 0 row index.
- req0_x  in  IDX_BITS  channel 0 column index.
- rsp0_valid  out  1  channel 0 texel valid (one-cycle pulse).
- rsp0_data  out  DATA_BITS  channel 0 texel.
- req1_valid, req1_ready, req1_texture, req1_y, req1_x, rsp1_valid, rsp1_data: same as channel 0, for channel 1.
- rom_texture  out  TEX_BITS  registered ROM texture select.
- rom_y_idx  out  IDX_BITS  registered ROM row index.
- rom_x_idx  out  IDX_BITS  registered ROM column index.
- rom_val  in  DATA_BITS  ROM read data, valid one edge after address.

## Operation
- Arbitration (combinational): the grant goes to a channel with valid high when en=1. With both valid: grant the channel opposite to last_grant. With one valid: grant it regardless of last_grant. With en=0 or neither valid: no grant.
- reqN_ready = grant to N. It is independent of reqN_valid only through the rule above; ready is never high without valid.
- Acceptance = reqN_valid & reqN_ready at a rising edge. On acceptance, register the channel's {texture, y, x} into rom_* and update last_grant <= N.
- last_grant changes only on acceptance. With no acceptance, rom_* and last_grant hold.
- In-flight tracking: a 2-stage tag pipeline of {busy, id}. Stage 1 loads {accepted, N}. Stage 2 loads stage 1.
- Response: at each edge, rsp_data register <= rom_val when stage 2 is busy. rspN_valid <= stage2.busy & (stage2.id == N).
- Both rspN_data outputs may share one register; it is only meaningful while the corresponding valid is high.
- Responses have no backpressure. Requesters must accept on the rsp valid pulse.
- Request order is preserved per channel and globally.
- Requesters must hold valid and fields stable until accepted. The arbiter never drops an accepted request except on reset.

## Timing
- Reset values: req0_ready=0, req1_ready=0 (while reset asserted), rsp0_valid=0, rsp1_valid=0, rsp*_data=0, rom_texture=0, rom_y_idx=0, rom_x_idx=0, last_grant=1 (channel 0 wins the first tie), tag pipeline not busy.
- Latency: request accepted at edge E → rom_* valid after E → ROM samples at E+1 → rspN_valid and data high for the single cycle following edge E+2. The fixed latency is 3 edges.
- Throughput: one acceptance per cycle, sustained. Under continuous contention, grants alternate 0,1,0,1,…
- en deasserted mid-stream: no new grants from the next cycle. Already in-flight reads still complete and respond.
- Reset asserted mid-operation: in-flight reads are discarded, no rsp pulses follow, and last_grant returns to 1.
- Simultaneous acceptance and response in the same cycle is normal pipelined operation and must not interfere.

## Test plan
- Reset: assert reset with both channels valid → all outputs 0, ready low. Release reset with both valid → first grant to channel 0.
- Single channel: channel 0 requests tex=3, y=7, x=12 for one acceptance, with the ROM model holding value 0xA at that address → rom_* = {3,7,12} after the acceptance edge, and rsp0_valid pulses with data 0xA exactly 3 edges after acceptance. rsp1_valid stays 0.
- Contention: both channels valid continuously for 8 cycles with distinct addresses → grants alternate 0,1,0,1,… Every response goes to the correct channel with the correct data, in order, with no gaps.
- Unbalanced load: channel 1 valid every cycle, channel 0 valid on cycles 3 and 4 only → channel 1 granted back-to-back except on the cycles where channel 0 wins round-robin. Channel 0 is served within 1 cycle of asserting valid.
- Enable gating: drop en for 4 cycles while both channels are valid → ready=0 throughout. The 2 in-flight reads still return. Grants resume on re-enable.
- Reset mid-flight: assert reset 1 cycle after an acceptance → no rsp pulse is ever produced for that request, and state returns to reset values.
